// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RAM loader: receiver states and bit-timing defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWrite,
        StBreak
    } uart_state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    // Start-bit check lands mid-bit, so the first wait is half a bit period.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/SyncChain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module SyncChain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic s_reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (s_reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with synchronous clear; ticks on the last cycle of each period.
module uart_baud_tick #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             s_reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (s_reset || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// 8N1 UART receiver that writes the low nibble of each good byte to a 32x4 RAM
// at an auto-incrementing address.
module uart_ram_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned NIB_W        = 4
) (
    input  logic              clk,
    input  logic              s_reset,
    input  logic              rx,
    input  logic              clear_addr,
    output logic [NIB_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wren,
    output logic [7:0]        rx_byte,
    output logic              byte_valid,
    output logic              frame_err,
    output logic              busy,
    output logic              wrapped
);

    localparam int unsigned HALF_BIT = half_bit(CLKS_PER_BIT);
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);

    uart_state_t       state_q, state_d;
    logic              rx_s, rx_prev_q, rx_fall;
    logic              fall_pend_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_byte_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wrapped_q;
    logic              frame_err_q;
    logic              baud_clear, baud_half, baud_tick;
    logic              shift_en, load_byte, set_ferr;
    logic [CNT_W-1:0]  baud_limit;

    SyncChain #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .s_reset (s_reset),
        .d       (rx),
        .q       (rx_s)
    );

    assign baud_limit = baud_half ? CNT_W'(HALF_BIT) : CNT_W'(CLKS_PER_BIT);

    uart_baud_tick #(
        .CNT_W (CNT_W)
    ) u_baud (
        .clk     (clk),
        .s_reset (s_reset),
        .clear   (baud_clear),
        .limit   (baud_limit),
        .tick    (baud_tick)
    );

    assign rx_fall = rx_prev_q & ~rx_s;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        baud_clear = 1'b0;
        baud_half  = 1'b0;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        set_ferr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_clear = 1'b1;
                // An edge seen during the write cycle is honoured here one cycle late.
                if (rx_fall || fall_pend_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                baud_half = 1'b1;
                if (baud_tick) begin
                    baud_clear = 1'b1;
                    bit_cnt_d  = 3'd0;
                    state_d    = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (rx_s) begin
                        load_byte = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StWrite: begin
                baud_clear = 1'b1;
                state_d    = StIdle;
            end
            StBreak: begin
                baud_clear = 1'b1;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q     <= StIdle;
            rx_prev_q   <= 1'b1;
            fall_pend_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_byte_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_s;
            fall_pend_q <= (state_q == StWrite) && rx_fall;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= set_ferr;
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
            if (load_byte) begin
                rx_byte_q <= shift_q;
            end
        end
    end

    // Clear wins over the post-write increment when both land on the same edge.
    always_ff @(posedge clk) begin
        if (s_reset || clear_addr) begin
            wr_addr_q <= '0;
            wrapped_q <= 1'b0;
        end else if (state_q == StWrite) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == {ADDR_W{1'b1}}) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    assign wren       = (state_q == StWrite);
    assign byte_valid = wren;
    assign rx_byte    = rx_byte_q;
    assign wr_data    = rx_byte_q[NIB_W-1:0];
    assign wr_addr    = wr_addr_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);
    assign wrapped    = wrapped_q;

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Upstream feeder for the 32x4 RAM write port. It receives 8N1 UART frames on one GPIO line and extracts the low nibble of each good byte.
- For each good byte it emits a single-cycle write strobe, with data and an auto-incrementing 5-bit write address.
- It replaces the loose timer, shift-register and edge-detector glue with one self-contained, mid-bit-sampling receiver plus address sequencer.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (50 MHz / 57600 baud).
- ADDR_W, 5, RAM write-address width (32 entries).
- NIB_W, 4, RAM data width; always the low NIB_W bits of the received byte.

Ports:
- clk  input  1  system clock, 50 MHz.
- s_reset  input  1  synchronous, active-high reset.
- rx  input  1  raw asynchronous UART line; idles high.
- clear_addr  input  1  synchronous pulse that returns the write address to 0.
- wr_data  output  NIB_W  RAM data; equals rx_byte[NIB_W-1:0].
- wr_addr  output  ADDR_W  RAM write address.
- wren  output  1  one-cycle RAM write enable.
- rx_byte  output  8  last good byte, held until the next good byte.
- byte_valid  output  1  one-cycle strobe; coincident with wren.
- frame_err  output  1  one-cycle strobe when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.
- wrapped  output  1  sticky; set when wr_addr rolls from 31 to 0.

Behaviour:
- rx passes through a 2-flop synchronizer; all sampling uses the synchronized value rx_s. Input latency is 2 clk cycles.
- Reset values, applied while s_reset is high: state IDLE, wr_addr 0, wr_data 0, rx_byte 0, wren 0, byte_valid 0, frame_err 0, wrapped 0, bit counter 0, baud counter 0.
- Reset asserted mid-frame aborts the frame and produces no write.
- IDLE: when a falling edge is detected on rx_s, clear the baud counter and go to START.
- START: count CLKS_PER_BIT/2 cycles (434), then sample.
  - rx_s low: go to DATA and clear the baud counter.
  - rx_s high: false start; return to IDLE with no outputs.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After 8 samples, go to STOP.
  - The bit counter is 3 bits and terminates at 7.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - High: go to WRITE.
  - Low: pulse frame_err for 1 cycle, make no write, go to BREAK.
- WRITE (1 cycle):
  - rx_byte takes the shift value; wr_data takes shift[3:0].
  - wren and byte_valid are high for exactly this one cycle.
  - wr_addr holds the pre-increment value during wren and increments on the following edge.
  - Then go to IDLE.
- BREAK: wait until rx_s is high, then go to IDLE. A held-low line therefore never retriggers.
- Address wrap: wr_addr is modulo 2^ADDR_W; 31+1 gives 0 and sets wrapped. wrapped clears only on s_reset or clear_addr.
- clear_addr in the same cycle as wren: the write completes at the current wr_addr. The next wr_addr is 0 (clear beats increment), and wrapped is cleared.
- clear_addr during a frame: the address clears immediately and the frame continues; the byte lands at address 0.
- A new start edge arriving during WRITE is handled next cycle from IDLE. The minimum spacing between wren pulses is 10*CLKS_PER_BIT cycles.
- Timing from the start falling edge on rx to wren ≈ 2 + 434 + 8*868 + 868 + 1 cycles; the bench checks wren with a ±2-cycle window.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, WRITE, BREAK;
  - CLKS_PER_BIT_DEFAULT = 868;
  - HALF_BIT = CLKS_PER_BIT/2.
- One natural sub-module: uart_baud_tick, a counter with synchronous clear that emits a terminal-count tick at a programmable limit.
- The synchronizer reuses the existing SyncChain module.

Test Plan:
- Send 0x35 after reset -> one wren pulse; wr_addr=0, wr_data=0x5, rx_byte=0x35, byte_valid coincident with wren; wr_addr reads 1 afterwards.
- Send 33 bytes 0x00..0x20 back-to-back -> 33 wren pulses with addresses 0..31 then 0. wrapped rises after the 32nd write. The final write has wr_data 0x0 at address 0.
- 200-cycle low glitch on rx -> returns to IDLE at the half-bit check; no wren, no frame_err; busy drops within 436 cycles.
- Frame 0xA7 with stop bit forced low, line held low for 3 bit times, then 0x1C -> one frame_err pulse and no write. Then a single wren with wr_data 0xC at the unchanged address.
- clear_addr pulsed in the exact cycle of wren for byte 0x0F at addr 9 -> write goes to addr 9; next byte 0x02 is written to addr 0.
- s_reset asserted mid-DATA of 0xFF, released, then 0x44 sent -> no write for 0xFF; 0x44 written at addr 0 with wr_data 0x4.
